// File: rtl/bch_encoder.sv
// Systematic BCH(63,51) t=2 serial encoder, generator x^12+x^10+x^8+x^5+x^4+x^3+1, MSB (x^62) first.
// Define BCH_ENC_ERR_INJECT_EN to add per-frame test error injection on the output bit stream.
module bch_encoder #(
    parameter logic [12:0] GEN_POLY = 13'h1539
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_data,
    input  logic       out_ready,
`ifdef BCH_ENC_ERR_INJECT_EN
    input  logic [1:0] inj_en,
    input  logic [5:0] inj_pos0,
    input  logic [5:0] inj_pos1,
`endif
    output logic       out_last
);

    localparam int N = 63;
    localparam int K = 51;

    typedef enum logic {ST_MSG, ST_PARITY} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [11:0] lfsr, lfsr_nxt;
    logic        out_valid_nxt, out_data_nxt, out_last_nxt;
    logic        ld, in_xfer, fb, flip;
    logic [5:0]  pos;

    assign ld       = ~out_valid | out_ready;
    assign in_ready = ~rst & (state == ST_MSG) & ld;
    assign in_xfer  = in_valid & in_ready;
    assign fb       = in_data ^ lfsr[11];
    assign pos      = (state == ST_MSG) ? cnt : cnt + 6'(K);

`ifdef BCH_ENC_ERR_INJECT_EN
    logic [1:0] inj_en_q, en_e;
    logic [5:0] pos0_q, pos1_q, pos0_e, pos1_e;
    logic       first_bit;

    // The first bit of a frame uses the live injection inputs; the rest use the latched copy.
    assign first_bit = (state == ST_MSG) && (cnt == 6'd0);
    assign en_e      = first_bit ? inj_en   : inj_en_q;
    assign pos0_e    = first_bit ? inj_pos0 : pos0_q;
    assign pos1_e    = first_bit ? inj_pos1 : pos1_q;
    assign flip      = (en_e[0] && (pos == pos0_e)) || (en_e[1] && (pos == pos1_e));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_en_q <= 2'b00;
            pos0_q   <= 6'd0;
            pos1_q   <= 6'd0;
        end else if (in_xfer && first_bit) begin
            inj_en_q <= inj_en;
            pos0_q   <= inj_pos0;
            pos1_q   <= inj_pos1;
        end
    end
`else
    assign flip = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lfsr_nxt      = lfsr;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_last_nxt  = out_last;
        case (state)
            ST_MSG: begin
                if (in_xfer) begin
                    out_data_nxt  = in_data ^ flip;
                    out_valid_nxt = 1'b1;
                    out_last_nxt  = 1'b0;
                    lfsr_nxt      = {lfsr[10:0], 1'b0} ^ (fb ? GEN_POLY[11:0] : 12'h000);
                    if (cnt == 6'(K - 1)) begin
                        cnt_nxt   = 6'd0;
                        state_nxt = ST_PARITY;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end else if (ld) begin
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                end
            end
            ST_PARITY: begin
                if (ld) begin
                    out_data_nxt  = lfsr[11] ^ flip;
                    out_valid_nxt = 1'b1;
                    out_last_nxt  = 1'b0;
                    lfsr_nxt      = {lfsr[10:0], 1'b0};
                    cnt_nxt       = cnt + 6'd1;
                    if (cnt == 6'(N - K - 1)) begin
                        out_last_nxt = 1'b1;
                        lfsr_nxt     = 12'h000;
                        cnt_nxt      = 6'd0;
                        state_nxt    = ST_MSG;
                    end
                end
            end
            default: state_nxt = ST_MSG;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_MSG;
            cnt       <= 6'd0;
            lfsr      <= 12'h000;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lfsr      <= lfsr_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_last  <= out_last_nxt;
        end
    end

endmodule

// File: tb/tb_bch_encoder.sv
// Self-checking bench for bch_encoder: directed frames plus random messages, gaps and stalls,
// checked against a polynomial long-division reference of m(x)*x^12 mod g(x).
module tb_bch_encoder;

    logic clk = 1'b0;
    logic rst, in_valid, in_data, out_ready;
    logic in_ready, out_valid, out_data, out_last;

    int n_tests = 0;
    int n_fail  = 0;
    bit in_q[$];
    bit exp_q[$];
    int acc = 0;
    bit bnd;

    always #5 clk = ~clk;

    bch_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
`ifdef BCH_ENC_ERR_INJECT_EN
        .inj_en    (2'b00),
        .inj_pos0  (6'd0),
        .inj_pos1  (6'd0),
`endif
        .out_last  (out_last)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_parity(input logic [50:0] m);
        logic [62:0] r;
        r = {m, 12'b0};
        for (int i = 62; i >= 12; i--)
            if (r[i]) r = r ^ (63'(13'h1539) << (i - 12));
        return r[11:0];
    endfunction

    function automatic logic [50:0] rand_msg();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[50:0];
    endfunction

    task automatic push_frame(input logic [50:0] m, input logic [11:0] p);
        for (int i = 50; i >= 0; i--) begin
            in_q.push_back(m[i]);
            exp_q.push_back(m[i]);
        end
        for (int i = 11; i >= 0; i--) exp_q.push_back(p[i]);
    endtask

    // Streams in_q into the DUT and checks every output beat against exp_q.
    task automatic run(input int gap, input int stall, output bit boundary);
        int idx = 0;
        int oidx = 0;
        int cyc = 0;
        bit prev_stall = 0;
        bit prev_d = 0;
        bit prev_l = 0;
        bit exp_rdy, last_beat;
        boundary = 0;
        while (oidx < exp_q.size() && cyc < 5000) begin
            @(negedge clk);
            in_valid  = (idx < in_q.size()) && ($urandom_range(99) >= gap);
            in_data   = (idx < in_q.size()) ? in_q[idx] : 1'b0;
            out_ready = ($urandom_range(99) >= stall);
            #1;
            last_beat = ((oidx % 63) == 62);
            exp_rdy   = (!out_valid || out_ready) && (acc < 51 || (out_valid && last_beat));
            chk("in_ready", in_ready, exp_rdy);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, prev_d);
                chk("stall_last", out_last, prev_l);
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
            if (out_valid && out_ready) begin
                chk("out_data", out_data, exp_q[oidx]);
                chk("out_last", out_last, last_beat);
                if (last_beat) begin
                    acc = 0;
                    if (in_valid && in_ready) boundary = 1;
                end
                oidx++;
            end
            if (in_valid && in_ready) begin
                idx++;
                acc++;
            end
            cyc++;
        end
        chk("run_complete", oidx == exp_q.size(), 1'b1);
        in_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // All-zero message gives an all-zero codeword.
        push_frame(51'd0, 12'h000);
        run(0, 0, bnd);

        // Message x^12 term only: remainder is g(x) minus its leading term.
        push_frame(51'd1, 12'h539);
        run(0, 0, bnd);

        // Same frame under input gaps and output stalls.
        push_frame(51'd1, 12'h539);
        run(40, 50, bnd);

        // Two random frames back to back, no gaps: next frame starts as the last bit leaves.
        for (int f = 0; f < 2; f++) begin
            logic [50:0] m;
            m = rand_msg();
            push_frame(m, ref_parity(m));
        end
        run(0, 0, bnd);
        chk("b2b_boundary", bnd, 1'b1);

        // Several random frames with random gaps and stalls.
        for (int f = 0; f < 3; f++) begin
            logic [50:0] m;
            m = rand_msg();
            push_frame(m, ref_parity(m));
        end
        run(30, 50, bnd);

        // Reset mid-frame, then a clean frame.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = 1'($urandom_range(1));
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("midrst_out_valid_hold", out_valid, 1'b0);
        rst = 1'b0;
        acc = 0;
        begin
            logic [50:0] m;
            m = rand_msg();
            push_frame(m, ref_parity(m));
        end
        run(20, 40, bnd);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
